// File: rtl/dht11_scheduler.sv
// -----------------------------------------------------------------------------
// dht11_scheduler
//
// Decides when a DHT11 read is attempted and keeps the last good reading.
// It triggers an external DHT11 controller with a one-cycle start pulse. It
// then waits for that controller's done pulse and checks the sensor checksum.
// On success it latches the result. On failure it retries up to MAX_RETRY
// times. Once the retries are used up, it reports the cause of the last
// failure.
//
// Attempts are separated by an idle gap of GAP_US microseconds. The same gap
// also follows reset, so the sensor can settle after power-up. Every time
// base comes from a free-running prescaler that makes a one-cycle us_tick
// every CLK_PER_US clocks.
//
// Ports
//   PCLK         in   clock (single clock domain)
//   PRESET       in   synchronous, active-high reset
//   en           in   auto mode: measure every gap while high
//   req          in   single-shot request pulse (held in a one-deep pending flag)
//   start_trig   out  one-cycle trigger to the DHT11 controller
//   done         in   one-cycle completion pulse from the controller
//   hmd/tmp/sum  in   raw humidity, temperature and checksum, valid with done
//   hmd_out      out  last checksum-valid humidity
//   tmp_out      out  last checksum-valid temperature
//   valid        out  sticky: at least one good result has been latched
//   upd          out  one-cycle pulse when hmd_out/tmp_out change
//   busy         out  high while triggering or waiting for done
//   err_cksum    out  sticky: last exhausted sequence failed on checksum
//   err_timeout  out  sticky: last exhausted sequence failed on timeout
// -----------------------------------------------------------------------------
module dht11_scheduler #(
  parameter int CLK_PER_US = 100,
  parameter int GAP_US     = 2000000,
  parameter int TIMEOUT_US = 25000,
  parameter int MAX_RETRY  = 3
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        en,
  input  logic        req,
  output logic        start_trig,
  input  logic        done,
  input  logic [15:0] hmd,
  input  logic [15:0] tmp,
  input  logic [7:0]  sum,
  output logic [15:0] hmd_out,
  output logic [15:0] tmp_out,
  output logic        valid,
  output logic        upd,
  output logic        busy,
  output logic        err_cksum,
  output logic        err_timeout
);

  // Each counter only needs to reach its terminal value (parameter - 1).
  // The counter stops there and leaves the state, so it never wraps. The
  // retry count has to hold MAX_RETRY itself.
  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US)    : 1;
  localparam int GW = (GAP_US     > 1) ? $clog2(GAP_US)        : 1;
  localparam int TW = (TIMEOUT_US > 1) ? $clog2(TIMEOUT_US)    : 1;
  localparam int RW = (MAX_RETRY  > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_US - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_US - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_US - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_GAP,
    S_IDLE,
    S_TRIG,
    S_WAIT_DONE
  } state_e;

  state_e          state_q,   state_d;
  logic [PW-1:0]   presc_q,   presc_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [TW-1:0]   to_cnt_q,  to_cnt_d;
  logic [RW-1:0]   retry_q,   retry_d;
  logic            pending_q, pending_d;
  logic [15:0]     hmd_out_q, hmd_out_d;
  logic [15:0]     tmp_out_q, tmp_out_d;
  logic            valid_q,   valid_d;
  logic            upd_q,     upd_d;
  logic            err_c_q,   err_c_d;
  logic            err_t_q,   err_t_d;

  logic            us_tick;
  logic [7:0]      cksum;
  logic            fail;
  logic            fail_timeout;

  assign us_tick = (presc_q == PRESC_LAST);

  // Byte sum in an 8-bit context, so the carry out of bit 7 is dropped.
  // That gives the modulo-256 sensor checksum.
  assign cksum = hmd[15:8] + hmd[7:0] + tmp[15:8] + tmp[7:0];

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    presc_d      = us_tick ? '0 : presc_q + 1'b1;
    gap_cnt_d    = gap_cnt_q;
    to_cnt_d     = to_cnt_q;
    retry_d      = retry_q;
    pending_d    = pending_q | req;
    hmd_out_d    = hmd_out_q;
    tmp_out_d    = tmp_out_q;
    valid_d      = valid_q;
    upd_d        = 1'b0;
    err_c_d      = err_c_q;
    err_t_d      = err_t_q;
    fail         = 1'b0;
    fail_timeout = 1'b0;

    unique case (state_q)
      S_GAP: begin
        if (us_tick) begin
          if (gap_cnt_q == GAP_LAST) begin
            // A non-zero retry count means this gap follows a failure that
            // still has retries left. That retry goes ahead whatever en and
            // pending are doing.
            state_d = (retry_q != '0) ? S_TRIG : S_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
      end

      S_IDLE: begin
        if (pending_q || en) state_d = S_TRIG;
      end

      S_TRIG: begin
        state_d  = S_WAIT_DONE;
        to_cnt_d = '0;
      end

      S_WAIT_DONE: begin
        // done is tested before the timeout. A done that lands on the expiry
        // tick therefore still counts as an answer.
        if (done) begin
          if (cksum == sum) begin
            hmd_out_d = hmd;
            tmp_out_d = tmp;
            valid_d   = 1'b1;
            upd_d     = 1'b1;
            err_c_d   = 1'b0;
            err_t_d   = 1'b0;
            retry_d   = '0;
            state_d   = S_GAP;
          end else begin
            fail = 1'b1;
          end
        end else if (us_tick) begin
          if (to_cnt_q == TO_LAST) begin
            fail         = 1'b1;
            fail_timeout = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = S_GAP;
    endcase

    // Both failure causes share one path. A failed attempt never touches the
    // latched result or valid.
    if (fail) begin
      state_d = S_GAP;
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 1'b1;
      end else begin
        retry_d = '0;
        err_t_d = fail_timeout;
        err_c_d = ~fail_timeout;
      end
    end

    // The gap always starts from zero. A request is consumed by whichever
    // trigger comes next, so one arriving on that same edge is served by it.
    if (state_d == S_GAP  && state_q != S_GAP)  gap_cnt_d = '0;
    if (state_d == S_TRIG && state_q != S_TRIG) pending_d = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    // NOTE: registers use non-blocking assignments. All of them then update
    // together from the values held before the edge, whatever order the
    // statements are written in.
    if (PRESET) begin
      state_q   <= S_GAP;
      presc_q   <= '0;
      gap_cnt_q <= '0;
      to_cnt_q  <= '0;
      retry_q   <= '0;
      pending_q <= 1'b0;
      hmd_out_q <= '0;
      tmp_out_q <= '0;
      valid_q   <= 1'b0;
      upd_q     <= 1'b0;
      err_c_q   <= 1'b0;
      err_t_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      gap_cnt_q <= gap_cnt_d;
      to_cnt_q  <= to_cnt_d;
      retry_q   <= retry_d;
      pending_q <= pending_d;
      hmd_out_q <= hmd_out_d;
      tmp_out_q <= tmp_out_d;
      valid_q   <= valid_d;
      upd_q     <= upd_d;
      err_c_q   <= err_c_d;
      err_t_q   <= err_t_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign start_trig  = (state_q == S_TRIG);
  assign busy        = (state_q == S_TRIG) || (state_q == S_WAIT_DONE);
  assign hmd_out     = hmd_out_q;
  assign tmp_out     = tmp_out_q;
  assign valid       = valid_q;
  assign upd         = upd_q;
  assign err_cksum   = err_c_q;
  assign err_timeout = err_t_q;

endmodule
